axi_s2m_m3: RTL
===============

// Module: axi_s2m_m3
// PURPOSE
//  Response-path router for one master port: collects B and R responses from 3 slaves and returns to
//  its master only those whose SID master field matches MASTER_ID; strips the {slv,mid} prefix from
//  the ID. Locks the R channel per burst (until RLAST) and the B channel per beat.
//  One instance per master.
// PARAMETERS
//  MASTER_ID  2'd1          master code carried in SID[W_ID+1:W_ID] (legal 1..3)
//  W_CID      4             channel-ID prefix width {slv[1:0],mid[1:0]}
//  W_ID       4             master-side ID width
//  W_DATA     32            read data width
//  W_SID      W_CID+W_ID    slave-side ID width
//  NUM_SLAVE  3             number of slave ports (fixed 3)
// PORTS
//  AXI_CLK        in   1       clock
//  AXI_RSTn       in   1       asynchronous active-low reset
//  Sn_BID         in   W_SID   n=0..2, write response ID
//  Sn_BRESP       in   2       write response
//  Sn_BVALID      in   1       write response valid
//  Sn_BREADY      out  1       write response ready
//  Sn_RID         in   W_SID   read ID
//  Sn_RDATA       in   W_DATA  read data
//  Sn_RRESP       in   2       read response
//  Sn_RLAST       in   1       last read beat
//  Sn_RVALID      in   1       read valid
//  Sn_RREADY      out  1       read ready
//  M_BID          out  W_ID    SID[W_ID-1:0] of granted slave
//  M_BRESP, M_BVALID  out  2,1 ; M_BREADY in 1
//  M_RID          out  W_ID    SID[W_ID-1:0] of granted slave
//  M_RDATA, M_RRESP, M_RLAST, M_RVALID  out  W_DATA,2,1,1 ; M_RREADY in 1
//  arbiter_type   in   1       0=fixed priority S0>S1>S2, 1=round robin
//  channel_en     in   1       0 blocks new grants
// BEHAVIOUR
//  - Request: Rreq[n] = channel_en & Sn_RVALID & (Sn_RID[W_ID+1:W_ID]==MASTER_ID); Breq likewise.
//  - Each channel has a one-hot grant register and a state: IDLE / LOCK. Reset: IDLE, grant=0,
//    RR pointer favours S0. All outputs 0 and all Sn_xREADY 0 after reset.
//  - IDLE: if any req, winner loaded into grant at next edge -> LOCK. First beat reaches the master
//    1 cycle after Sn_xVALID rises.
//  - LOCK: M_xVALID = Sn_xVALID of the granted slave; Sn_xREADY = grant[n] & M_xREADY;
//    master-side data/ID mux = granted slave, else all 0. Ungranted slaves see READY=0.
//  - Release R: M_RVALID & M_RREADY & M_RLAST. Release B: M_BVALID & M_BREADY.
//    On release, the same edge loads the next winner if any req (no bubble), else -> IDLE.
//  - RR: search starts at slave after last granted, wrapping 2->0. Fixed: lowest index wins.
//    An arbiter_type change applies at the next arbitration only.
//  - Simultaneous: R and B are independent. Requests from other masters' SIDs are ignored and left
//    stalled (READY=0).
//  - channel_en low in LOCK: current burst runs to release, then no new grant.
//    channel_en low in IDLE: stays IDLE.
//  - VALID dropping while granted (protocol violation): grant is held, output VALID follows input.
//  - Async reset mid-burst: immediate return to reset state, and the burst is abandoned.
// STRUCTURE
//  - axi_ic_pkg: SID field positions (SID_SLV_LSB=W_ID+2, SID_MID_LSB=W_ID), MID codes 1..3,
//    ARB_FIXED=0 / ARB_RR=1.
//  - Sub-module axi_arbiter_s2m_m3 (req[2:0], last, hs, arbiter_type -> grant[2:0]) is
//    instantiated twice: R with last=M_RLAST, B with last=1'b1.
// TESTING
//  - Single read: S1 RID=8'h25 (MID 2), MASTER_ID=2, RLAST burst of 4 -> 4 beats, M_RID=4'h5,
//    grant S1 held until the 4th beat.
//  - Filter: S0 BID=8'h13 (MID 1) with MASTER_ID=2 -> M_BVALID stays 0 and S0_BREADY stays 0
//    for 20 cycles.
//  - Fixed priority: S0,S1,S2 all RVALID, 1-beat, arbiter_type=0 -> order S0,S1,S2;
//    re-assert S0 after each -> S0 always first.
//  - Round robin: S0..S2 continuously requesting B, arbiter_type=1 -> grants 0,1,2,0,1,2
//    with no idle cycles between handshakes.
//  - Backpressure/lock: S2 burst len 3, M_RREADY toggling, S0 requests mid-burst
//    -> S0 not served until S2 RLAST handshake.
//  - Reset mid-burst with AXI_RSTn low for 1 cycle -> all READY/VALID=0 immediately,
//    state IDLE, next grant goes to S0.

Source files
------------

// File: rtl/axi_ic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ic_pkg
// Description : Shared constants, types and helpers for the slave-to-master
//               response routers (SID field positions, master codes,
//               arbitration modes, channel state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ic_pkg;

   // SID layout for the default master-side ID width: {slv[1:0], mid[1:0], id}
   localparam int DEF_W_ID    = 4;
   localparam int SID_MID_LSB = DEF_W_ID;
   localparam int SID_SLV_LSB = DEF_W_ID + 2;

   // Master codes carried in the SID master field (0 is never a legal master)
   localparam logic [1:0] MID_M1 = 2'd1;
   localparam logic [1:0] MID_M2 = 2'd2;
   localparam logic [1:0] MID_M3 = 2'd3;

   // Arbitration modes
   localparam logic ARB_FIXED = 1'b0;
   localparam logic ARB_RR    = 1'b1;

   // Number of slave ports served by one router
   localparam int NUM_SLV = 3;

   // Per-channel routing state
   typedef enum logic {
      CH_IDLE = 1'b0,
      CH_LOCK = 1'b1
   } ch_state_e;

   // Master field LSB inside a SID for a given master-side ID width
   function automatic int sid_mid_lsb(input int w_id);
      return w_id;
   endfunction

   // Slave field LSB inside a SID for a given master-side ID width
   function automatic int sid_slv_lsb(input int w_id);
      return w_id + 2;
   endfunction

   // (base + ofs) modulo 3, for base in 0..2 and ofs in 0..3
   function automatic logic [1:0] slv_wrap(input logic [1:0] base, input logic [1:0] ofs);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, ofs};
      if (sum >= 3'd3) begin
         sum = sum - 3'd3;
      end
      return sum[1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_arbiter_s2m_m3.sv
`default_nettype none
// ============================================================================
// Module      : axi_arbiter_s2m_m3
// Description : Three-way response arbiter with channel lock. Holds a one-hot
//               grant from the arbitration win until a handshake that carries
//               'last', then re-arbitrates on the same edge. Fixed priority
//               (S0 highest) or round robin starting after the last winner.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_arbiter_s2m_m3
   import axi_ic_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] req,
   input  logic       last,
   input  logic       hs,
   input  logic       arbiter_type,
   output logic [2:0] grant
);

   ch_state_e  state_q, state_d;
   logic [2:0] grant_q, grant_d;
   logic [1:0] ptr_q,   ptr_d;      // index of the most recently granted slave

   logic       w_release;
   logic [2:0] w_req_eff;
   logic [2:0] w_win_oh;
   logic [1:0] w_win_idx;
   logic [1:0] w_cand;

   // The granted slave's VALID during its releasing handshake belongs to the
   // transfer being completed, so it must not count as a fresh request;
   // otherwise a single-response slave would be re-granted and lock the channel.
   assign w_release = (state_q == CH_LOCK) & hs & last;
   assign w_req_eff = req & ~(w_release ? grant_q : 3'b000);
   assign grant     = grant_q;

   // Pick the winner among the effective requests for the active mode
   always_comb begin
      w_win_oh  = 3'b000;
      w_win_idx = 2'd0;
      w_cand    = 2'd0;
      if (arbiter_type == ARB_FIXED) begin
         for (int i = 2; i >= 0; i--) begin
            if (w_req_eff[i]) begin
               w_win_oh    = 3'b000;
               w_win_oh[i] = 1'b1;
               w_win_idx   = 2'(i);
            end
         end
      end else begin
         // Offsets 3..1 visited in reverse so the nearest slave after the pointer wins
         for (int k = 3; k >= 1; k--) begin
            w_cand = slv_wrap(ptr_q, 2'(k));
            if (w_req_eff[w_cand]) begin
               w_win_oh         = 3'b000;
               w_win_oh[w_cand] = 1'b1;
               w_win_idx        = w_cand;
            end
         end
      end
   end

   // Next-state, grant and pointer update
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         CH_IDLE: begin
            if (|w_req_eff) begin
               state_d = CH_LOCK;
               grant_d = w_win_oh;
               ptr_d   = w_win_idx;
            end
         end
         CH_LOCK: begin
            if (w_release) begin
               if (|w_req_eff) begin
                  grant_d = w_win_oh;
                  ptr_d   = w_win_idx;
               end else begin
                  state_d = CH_IDLE;
                  grant_d = 3'b000;
               end
            end
         end
         default: begin
            state_d = CH_IDLE;
            grant_d = 3'b000;
         end
      endcase
   end

   // State registers; pointer resets to S2 so the first round-robin search starts at S0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CH_IDLE;
         grant_q <= 3'b000;
         ptr_q   <= 2'd2;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_s2m_m3.sv
`default_nettype none
// ============================================================================
// Module      : axi_s2m_m3
// Description : Response-path router for one master port. Collects B and R
//               responses from three slaves, forwards only those addressed to
//               MASTER_ID, strips the {slv,mid} SID prefix, locks R per burst
//               and B per beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_s2m_m3
   import axi_ic_pkg::*;
#(
   parameter logic [1:0] MASTER_ID = 2'd1,
   parameter int         W_CID     = 4,
   parameter int         W_ID      = 4,
   parameter int         W_DATA    = 32,
   parameter int         W_SID     = W_CID + W_ID,
   parameter int         NUM_SLAVE = 3
)(
   input  logic              AXI_CLK,
   input  logic              AXI_RSTn,
   // slave 0
   input  logic [W_SID-1:0]  S0_BID,
   input  logic [1:0]        S0_BRESP,
   input  logic              S0_BVALID,
   output logic              S0_BREADY,
   input  logic [W_SID-1:0]  S0_RID,
   input  logic [W_DATA-1:0] S0_RDATA,
   input  logic [1:0]        S0_RRESP,
   input  logic              S0_RLAST,
   input  logic              S0_RVALID,
   output logic              S0_RREADY,
   // slave 1
   input  logic [W_SID-1:0]  S1_BID,
   input  logic [1:0]        S1_BRESP,
   input  logic              S1_BVALID,
   output logic              S1_BREADY,
   input  logic [W_SID-1:0]  S1_RID,
   input  logic [W_DATA-1:0] S1_RDATA,
   input  logic [1:0]        S1_RRESP,
   input  logic              S1_RLAST,
   input  logic              S1_RVALID,
   output logic              S1_RREADY,
   // slave 2
   input  logic [W_SID-1:0]  S2_BID,
   input  logic [1:0]        S2_BRESP,
   input  logic              S2_BVALID,
   output logic              S2_BREADY,
   input  logic [W_SID-1:0]  S2_RID,
   input  logic [W_DATA-1:0] S2_RDATA,
   input  logic [1:0]        S2_RRESP,
   input  logic              S2_RLAST,
   input  logic              S2_RVALID,
   output logic              S2_RREADY,
   // master
   output logic [W_ID-1:0]   M_BID,
   output logic [1:0]        M_BRESP,
   output logic              M_BVALID,
   input  logic              M_BREADY,
   output logic [W_ID-1:0]   M_RID,
   output logic [W_DATA-1:0] M_RDATA,
   output logic [1:0]        M_RRESP,
   output logic              M_RLAST,
   output logic              M_RVALID,
   input  logic              M_RREADY,
   // control
   input  logic              arbiter_type,
   input  logic              channel_en
);

   localparam int MID_LSB = sid_mid_lsb(W_ID);
   localparam int SLV_LSB = sid_slv_lsb(W_ID);

   logic [W_SID-1:0]     w_bid   [NUM_SLAVE];
   logic [1:0]           w_bresp [NUM_SLAVE];
   logic [W_SID-1:0]     w_rid   [NUM_SLAVE];
   logic [W_DATA-1:0]    w_rdata [NUM_SLAVE];
   logic [1:0]           w_rresp [NUM_SLAVE];
   logic [NUM_SLAVE-1:0] w_bvalid, w_rvalid, w_rlast;
   logic [NUM_SLAVE-1:0] w_b_req, w_r_req;
   logic [NUM_SLAVE-1:0] w_b_grant, w_r_grant;
   logic                 w_b_hs, w_r_hs;
   logic                 unused_slv_bits;

   assign w_bid[0]   = S0_BID;    assign w_bid[1]   = S1_BID;    assign w_bid[2]   = S2_BID;
   assign w_bresp[0] = S0_BRESP;  assign w_bresp[1] = S1_BRESP;  assign w_bresp[2] = S2_BRESP;
   assign w_rid[0]   = S0_RID;    assign w_rid[1]   = S1_RID;    assign w_rid[2]   = S2_RID;
   assign w_rdata[0] = S0_RDATA;  assign w_rdata[1] = S1_RDATA;  assign w_rdata[2] = S2_RDATA;
   assign w_rresp[0] = S0_RRESP;  assign w_rresp[1] = S1_RRESP;  assign w_rresp[2] = S2_RRESP;
   assign w_bvalid   = {S2_BVALID, S1_BVALID, S0_BVALID};
   assign w_rvalid   = {S2_RVALID, S1_RVALID, S0_RVALID};
   assign w_rlast    = {S2_RLAST,  S1_RLAST,  S0_RLAST};

   // A slave requests only when its response carries this master's code
   for (genvar i = 0; i < NUM_SLAVE; i++) begin : g_req
      assign w_b_req[i] = channel_en & w_bvalid[i] &
                          (w_bid[i][SLV_LSB-1:MID_LSB] == MASTER_ID);
      assign w_r_req[i] = channel_en & w_rvalid[i] &
                          (w_rid[i][SLV_LSB-1:MID_LSB] == MASTER_ID);
   end

   // The slave field is routing information only and is not forwarded
   always_comb begin
      unused_slv_bits = 1'b0;
      for (int i = 0; i < NUM_SLAVE; i++) begin
         unused_slv_bits = unused_slv_bits ^ (^w_bid[i][W_SID-1:SLV_LSB])
                                           ^ (^w_rid[i][W_SID-1:SLV_LSB]);
      end
   end

   assign w_r_hs = M_RVALID & M_RREADY;
   assign w_b_hs = M_BVALID & M_BREADY;

   // R stays locked for the whole burst
   axi_arbiter_s2m_m3 u_arb_r (
      .clk          (AXI_CLK),
      .rst_n        (AXI_RSTn),
      .req          (w_r_req),
      .last         (M_RLAST),
      .hs           (w_r_hs),
      .arbiter_type (arbiter_type),
      .grant        (w_r_grant)
   );

   // B is a single beat, so every handshake releases
   axi_arbiter_s2m_m3 u_arb_b (
      .clk          (AXI_CLK),
      .rst_n        (AXI_RSTn),
      .req          (w_b_req),
      .last         (1'b1),
      .hs           (w_b_hs),
      .arbiter_type (arbiter_type),
      .grant        (w_b_grant)
   );

   // Read channel mux: granted slave drives the master, zeros when nothing is granted
   always_comb begin
      M_RVALID = 1'b0;
      M_RID    = '0;
      M_RDATA  = '0;
      M_RRESP  = 2'b00;
      M_RLAST  = 1'b0;
      for (int i = 0; i < NUM_SLAVE; i++) begin
         if (w_r_grant[i]) begin
            M_RVALID = w_rvalid[i];
            M_RID    = w_rid[i][W_ID-1:0];
            M_RDATA  = w_rdata[i];
            M_RRESP  = w_rresp[i];
            M_RLAST  = w_rlast[i];
         end
      end
   end

   // Write-response mux: granted slave drives the master, zeros when nothing is granted
   always_comb begin
      M_BVALID = 1'b0;
      M_BID    = '0;
      M_BRESP  = 2'b00;
      for (int i = 0; i < NUM_SLAVE; i++) begin
         if (w_b_grant[i]) begin
            M_BVALID = w_bvalid[i];
            M_BID    = w_bid[i][W_ID-1:0];
            M_BRESP  = w_bresp[i];
         end
      end
   end

   // Only the granted slave sees the master's READY
   assign S0_RREADY = w_r_grant[0] & M_RREADY;
   assign S1_RREADY = w_r_grant[1] & M_RREADY;
   assign S2_RREADY = w_r_grant[2] & M_RREADY;
   assign S0_BREADY = w_b_grant[0] & M_BREADY;
   assign S1_BREADY = w_b_grant[1] & M_BREADY;
   assign S2_BREADY = w_b_grant[2] & M_BREADY;

endmodule
`default_nettype wire
